// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, controller state codes and fixed addresses
// used by the arbiter and the init/write/read sequencers.
package sdram_pkg;

    // Commands are {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] NOP      = 4'b0111;
    localparam logic [3:0] PRE      = 4'b0010;
    localparam logic [3:0] ACT      = 4'b0011;
    localparam logic [3:0] RD       = 4'b0101;
    localparam logic [3:0] WR       = 4'b0100;
    localparam logic [3:0] AREF_CMD = 4'b0001;

    // A10 high selects all banks for precharge.
    localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

    typedef enum logic [4:0] {
        IDLE  = 5'b0_0001,
        ARBIT = 5'b0_0010,
        AREF  = 5'b0_0100,
        WRITE = 5'b0_1000,
        READ  = 5'b1_0000
    } state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh timer: free-runs while enabled and raises ref_pending
// on every wrap until the arbiter acknowledges it by entering AREF.
module sdram_ref_timer #(
    parameter int REF_PERIOD = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic ref_pending
);

    localparam int W = $clog2(REF_PERIOD + 1);
    localparam logic [W-1:0] LAST = W'(REF_PERIOD - 1);

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = run && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // A wrap coinciding with the acknowledge wins so no refresh is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_pending <= 1'b0;
        end else if (wrap) begin
            ref_pending <= 1'b1;
        end else if (clear) begin
            ref_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Central SDRAM command scheduler: owns the one-hot controller state, arbitrates
// init / auto-refresh / write / read and drives the registered SDRAM pins.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = 780,
    parameter int AREF_LEN   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    output logic [4:0]  state,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_ba
);

    localparam logic [3:0] AREF_LAST = 4'(AREF_LEN - 1);

    state_t      state_q;
    state_t      state_next;
    logic        last_grant_read;
    logic        ref_pending;
    logic        ref_clear;
    logic [3:0]  aref_cnt;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic [3:0]  pin_cmd;
    logic [12:0] pin_addr;

    assign state    = state_q;
    assign sdram_ba = 2'b00;

    assign ref_clear = (state_next == AREF) && (state_q != AREF);

    sdram_ref_timer #(
        .REF_PERIOD(REF_PERIOD)
    ) u_ref_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state_q != IDLE),
        .clear      (ref_clear),
        .ref_pending(ref_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Refresh beats bursts; simultaneous bursts alternate on last_grant.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (init_done) state_next = ARBIT;
            end
            ARBIT: begin
                if (ref_pending)          state_next = AREF;
                else if (wr_req && rd_req) state_next = last_grant_read ? WRITE : READ;
                else if (wr_req)          state_next = WRITE;
                else if (rd_req)          state_next = READ;
            end
            AREF: begin
                if (aref_cnt == AREF_LAST) state_next = ARBIT;
            end
            WRITE: begin
                if (wr_end) state_next = ARBIT;
            end
            READ: begin
                if (rd_end) state_next = ARBIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en           <= 1'b0;
            rd_en           <= 1'b0;
            last_grant_read <= 1'b1;
        end else begin
            wr_en <= (state_next == WRITE) && (state_q != WRITE);
            rd_en <= (state_next == READ) && (state_q != READ);
            if ((state_next == WRITE) && (state_q != WRITE)) last_grant_read <= 1'b0;
            else if ((state_next == READ) && (state_q != READ)) last_grant_read <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aref_cnt <= '0;
        end else if (state_q == AREF) begin
            aref_cnt <= aref_cnt + 4'd1;
        end else begin
            aref_cnt <= '0;
        end
    end

    always_comb begin
        aref_cmd  = NOP;
        aref_addr = '0;
        if (aref_cnt == 4'd1) begin
            aref_cmd  = PRE;
            aref_addr = PRE_ALL_ADDR;
        end else if (aref_cnt == 4'd3) begin
            aref_cmd  = AREF_CMD;
        end
    end

    always_comb begin
        pin_cmd  = NOP;
        pin_addr = '0;
        case (state_q)
            IDLE: begin
                pin_cmd  = init_cmd;
                pin_addr = init_addr;
            end
            AREF: begin
                pin_cmd  = aref_cmd;
                pin_addr = aref_addr;
            end
            WRITE: begin
                pin_cmd  = wr_cmd;
                pin_addr = wr_addr;
            end
            READ: begin
                pin_cmd  = rd_cmd;
                pin_addr = rd_addr;
            end
            default: begin
                pin_cmd  = NOP;
                pin_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_cmd  <= NOP;
            sdram_addr <= '0;
        end else begin
            sdram_cmd  <= pin_cmd;
            sdram_addr <= pin_addr;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset/init handoff, periodic refresh,
// round-robin grants, refresh deferred by a burst, async reset, spurious ends.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic [3:0]  init_cmd = NOP;
    logic [12:0] init_addr = '0;
    logic        wr_req = 1'b0;
    logic        wr_en;
    logic        wr_end = 1'b0;
    logic [3:0]  wr_cmd = WR;
    logic [12:0] wr_addr = 13'h0123;
    logic        rd_req = 1'b0;
    logic        rd_en;
    logic        rd_end = 1'b0;
    logic [3:0]  rd_cmd = RD;
    logic [12:0] rd_addr = 13'h1456;
    logic [4:0]  state;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;

    int checks = 0;
    int fails  = 0;

    sdram_arbiter #(.REF_PERIOD(780), .AREF_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .state(state), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
    );

    always #5 clk = ~clk;

    // Sample point sits 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for_state(input logic [4:0] target, input int budget, output int n);
        n = 0;
        while (state !== target && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [3:0]  prev_cmd;
        logic [12:0] prev_addr;
        tick();
        tick();
        checks++; if (state !== 5'b0_0001) begin fails++; $display("FAIL reset_state: got %b want %b", state, 5'b0_0001); end
        checks++; if (sdram_cmd !== 4'b0111) begin fails++; $display("FAIL reset_cmd: got %b want %b", sdram_cmd, 4'b0111); end
        checks++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b%b want 00", wr_en, rd_en); end
        checks++; if (sdram_ba !== 2'b00) begin fails++; $display("FAIL reset_ba: got %b want 00", sdram_ba); end
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            prev_cmd  = 4'(c * 3);
            prev_addr = 13'(c * 37 + 5);
            init_cmd  = prev_cmd;
            init_addr = prev_addr;
            tick();
            checks++; if (state !== 5'b0_0001) begin fails++; $display("FAIL idle_state c%0d: got %b want %b", c, state, 5'b0_0001); end
            checks++; if (sdram_cmd !== prev_cmd || sdram_addr !== prev_addr) begin
                fails++; $display("FAIL idle_pins c%0d: got %h/%h want %h/%h", c, sdram_cmd, sdram_addr, prev_cmd, prev_addr);
            end
        end
        init_done = 1'b1;
        init_cmd  = NOP;
        init_addr = '0;
        tick();
        checks++; if (state !== 5'b0_0010) begin fails++; $display("FAIL arbit_entry: got %b want %b", state, 5'b0_0010); end
    endtask

    task automatic test_refresh();
        int n;
        for (int t = 1; t <= 781; t++) begin
            tick();
            if (t == 779) begin
                checks++; if (dut.ref_pending !== 1'b0) begin fails++; $display("FAIL ref_early: got %b want 0", dut.ref_pending); end
            end
            if (t == 780) begin
                checks++; if (dut.ref_pending !== 1'b1 || state !== 5'b0_0010) begin
                    fails++; $display("FAIL ref_rise: got pend=%b state=%b want pend=1 state=00010", dut.ref_pending, state);
                end
            end
        end
        checks++; if (state !== 5'b0_0100) begin fails++; $display("FAIL aref_entry: got %b want %b", state, 5'b0_0100); end
        checks++; if (dut.ref_pending !== 1'b0) begin fails++; $display("FAIL ref_clear: got %b want 0", dut.ref_pending); end
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j == 2) begin
                checks++; if (sdram_cmd !== 4'b0010 || sdram_addr !== 13'h0400) begin
                    fails++; $display("FAIL aref_pre: got %b/%h want 0010/0400", sdram_cmd, sdram_addr);
                end
            end
            if (j == 4) begin
                checks++; if (sdram_cmd !== 4'b0001 || sdram_addr !== 13'h0000) begin
                    fails++; $display("FAIL aref_cmd: got %b/%h want 0001/0000", sdram_cmd, sdram_addr);
                end
            end
            if (j == 7) begin
                checks++; if (state !== 5'b0_0100) begin fails++; $display("FAIL aref_hold: got %b want 00100", state); end
            end
        end
        checks++; if (state !== 5'b0_0010) begin fails++; $display("FAIL aref_exit: got %b want 00010", state); end
        wait_for_state(5'b0_0100, 1000, n);
        checks++; if (n !== 772) begin fails++; $display("FAIL ref_period: got %0d want 772 cycles after exit", n); end
        for (int j = 1; j <= 8; j++) tick();
        checks++; if (state !== 5'b0_0010) begin fails++; $display("FAIL aref2_exit: got %b want 00010", state); end
    endtask

    task automatic test_round_robin();
        wr_req = 1'b1;
        rd_req = 1'b1;
        tick();
        checks++; if (state !== 5'b0_1000 || wr_en !== 1'b1 || rd_en !== 1'b0) begin
            fails++; $display("FAIL rr_first: got state=%b wr_en=%b rd_en=%b want 01000/1/0", state, wr_en, rd_en);
        end
        wr_req = 1'b0;
        tick();
        checks++; if (wr_en !== 1'b0 || state !== 5'b0_1000) begin fails++; $display("FAIL rr_wr_pulse: got wr_en=%b state=%b want 0/01000", wr_en, state); end
        checks++; if (sdram_cmd !== 4'b0100 || sdram_addr !== 13'h0123) begin
            fails++; $display("FAIL wr_pins: got %b/%h want 0100/0123", sdram_cmd, sdram_addr);
        end
        tick();
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        checks++; if (state !== 5'b0_0010 || rd_en !== 1'b0) begin fails++; $display("FAIL rr_wr_done: got state=%b rd_en=%b want 00010/0", state, rd_en); end
        tick();
        checks++; if (state !== 5'b1_0000 || rd_en !== 1'b1 || wr_en !== 1'b0) begin
            fails++; $display("FAIL rr_second: got state=%b rd_en=%b wr_en=%b want 10000/1/0", state, rd_en, wr_en);
        end
        rd_req = 1'b0;
        tick();
        checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL rr_rd_pulse: got %b want 0", rd_en); end
        checks++; if (sdram_cmd !== 4'b0101 || sdram_addr !== 13'h1456) begin
            fails++; $display("FAIL rd_pins: got %b/%h want 0101/1456", sdram_cmd, sdram_addr);
        end
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        checks++; if (state !== 5'b0_0010) begin fails++; $display("FAIL rr_rd_done: got %b want 00010", state); end
        wr_req = 1'b1;
        rd_req = 1'b1;
        tick();
        checks++; if (state !== 5'b0_1000 || wr_en !== 1'b1) begin fails++; $display("FAIL rr_repeat: got state=%b wr_en=%b want 01000/1", state, wr_en); end
        wr_req = 1'b0;
        tick();
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        tick();
        checks++; if (state !== 5'b1_0000 || rd_en !== 1'b1) begin fails++; $display("FAIL rr_repeat_rd: got state=%b rd_en=%b want 10000/1", state, rd_en); end
        rd_req = 1'b0;
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
    endtask

    task automatic test_refresh_during_read();
        int n;
        wait_for_state(5'b0_0100, 1000, n);
        checks++; if (state !== 5'b0_0100) begin fails++; $display("FAIL rdref_sync: got %b want 00100", state); end
        for (int j = 1; j <= 8; j++) tick();
        for (int j = 1; j <= 760; j++) tick();
        rd_req = 1'b1;
        for (int r = 0; r <= 14; r++) begin
            tick();
            if (r == 0) rd_req = 1'b0;
            if (r == 12) wr_req = 1'b1;
            if (r == 12) begin
                checks++; if (dut.ref_pending !== 1'b1) begin fails++; $display("FAIL rdref_pend: got %b want 1", dut.ref_pending); end
            end
            if (state !== 5'b1_0000) begin
                checks++; fails++; $display("FAIL rdref_hold r%0d: got %b want 10000", r, state);
            end
        end
        checks++;
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        checks++; if (state !== 5'b0_0010) begin fails++; $display("FAIL rdref_end: got %b want 00010", state); end
        tick();
        checks++; if (state !== 5'b0_0100 || wr_en !== 1'b0) begin fails++; $display("FAIL rdref_aref_first: got state=%b wr_en=%b want 00100/0", state, wr_en); end
        checks++; if (dut.ref_pending !== 1'b0) begin fails++; $display("FAIL rdref_clear: got %b want 0", dut.ref_pending); end
        for (int j = 1; j <= 8; j++) tick();
        tick();
        checks++; if (state !== 5'b0_1000 || wr_en !== 1'b1) begin fails++; $display("FAIL rdref_wr_after: got state=%b wr_en=%b want 01000/1", state, wr_en); end
        wr_req = 1'b0;
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        wr_cmd = WR;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        for (int j = 2; j <= 5; j++) tick();
        checks++; if (state !== 5'b0_1000 || sdram_cmd !== 4'b0100) begin
            fails++; $display("FAIL midwr_pre: got state=%b cmd=%b want 01000/0100", state, sdram_cmd);
        end
        #2;
        rst_n = 1'b0;
        init_done = 1'b0;
        #1;
        checks++; if (state !== 5'b0_0001 || sdram_cmd !== 4'b0111 || sdram_addr !== 13'h0 || wr_en !== 1'b0 || dut.ref_pending !== 1'b0) begin
            fails++; $display("FAIL midwr_async: got state=%b cmd=%b addr=%h wr_en=%b pend=%b want 00001/0111/0000/0/0",
                              state, sdram_cmd, sdram_addr, wr_en, dut.ref_pending);
        end
        #1;
        rst_n = 1'b1;
        wr_req = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (state !== 5'b0_0001 || wr_en !== 1'b0) begin
                checks++; fails++; $display("FAIL midwr_wait c%0d: got state=%b wr_en=%b want 00001/0", j, state, wr_en);
            end
        end
        checks++;
        init_done = 1'b1;
        tick();
        checks++; if (state !== 5'b0_0010 || wr_en !== 1'b0) begin fails++; $display("FAIL midwr_arbit: got state=%b wr_en=%b want 00010/0", state, wr_en); end
        tick();
        checks++; if (state !== 5'b0_1000 || wr_en !== 1'b1) begin fails++; $display("FAIL midwr_regrant: got state=%b wr_en=%b want 01000/1", state, wr_en); end
        wr_req = 1'b0;
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
    endtask

    task automatic test_spurious_end();
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        checks++; if (state !== 5'b0_0010 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
            fails++; $display("FAIL spur_rd: got state=%b rd_en=%b wr_en=%b want 00010/0/0", state, rd_en, wr_en);
        end
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        tick();
        checks++; if (state !== 5'b0_0010 || rd_en !== 1'b0 || wr_en !== 1'b0 || sdram_cmd !== 4'b0111) begin
            fails++; $display("FAIL spur_wr: got state=%b rd_en=%b wr_en=%b cmd=%b want 00010/0/0/0111", state, rd_en, wr_en, sdram_cmd);
        end
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_round_robin();
        test_refresh_during_read();
        test_reset_mid_write();
        test_spurious_end();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
